// File: rtl/rsa_pkg.sv
// Shared RSA types: operand width, modexp sequencing states and modmult handshake phases.
package rsa_pkg;

  localparam int RSA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_CHECK,
    ST_MUL,
    ST_SQR,
    ST_FINISH
  } modexp_state_t;

  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT,
    PH_RELEASE
  } op_phase_t;

endpackage

// File: rtl/modmult_issue.sv
// One modmult operation per go pulse: ISSUE raises mm_ready with stable operands,
// WAIT captures the product on mm_done, RELEASE waits for mm_done to fall.
module modmult_issue
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             mm_ready,
  output logic [WIDTH-1:0] mm_base,
  output logic [WIDTH-1:0] mm_power,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done,
  output logic             op_done,
  output logic [WIDTH-1:0] op_result
);

  op_phase_t phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= PH_ISSUE;
      mm_ready  <= 1'b0;
      mm_base   <= '0;
      mm_power  <= '0;
      op_done   <= 1'b0;
      op_result <= '0;
    end else begin
      op_done <= 1'b0;
      case (phase)
        PH_ISSUE: begin
          // mm_done is not looked at here, so a stray completion is ignored
          if (go) begin
            mm_base  <= a;
            mm_power <= b;
            mm_ready <= 1'b1;
            phase    <= PH_WAIT;
          end
        end
        PH_WAIT: begin
          if (mm_done) begin
            op_result <= mm_result;
            mm_ready  <= 1'b0;
            phase     <= PH_RELEASE;
          end
        end
        PH_RELEASE: begin
          if (!mm_done) begin
            op_done <= 1'b1;
            phase   <= PH_ISSUE;
          end
        end
        default: phase <= PH_ISSUE;
      endcase
    end
  end

endmodule

// File: rtl/modexp_controller.sv
// Right-to-left square-and-multiply sequencer for msg^exponent mod modulus over a shared modmult.
// Optional macro MODEXP_SKIP_LAST_SQR_EN: skip the final squaring when the exponent is down to 1.
module modexp_controller
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] msg,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] result,
  output logic             mm_ready,
  output logic [WIDTH-1:0] mm_base,
  output logic [WIDTH-1:0] mm_power,
  output logic [WIDTH-1:0] mm_denominator,
  input  logic [WIDTH-1:0] mm_result,
  input  logic             mm_done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  modexp_state_t    state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] msg_q;
  logic [WIDTH-1:0] mod_q;
  logic             err_q;
  logic             issued;
  logic             go;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_done;
  logic [WIDTH-1:0] op_result;

  assign mm_denominator = mod_q;

  modmult_issue #(.WIDTH(WIDTH)) u_issue (
    .clk       (clk),
    .reset_n   (reset_n),
    .go        (go),
    .a         (op_a),
    .b         (op_b),
    .mm_ready  (mm_ready),
    .mm_base   (mm_base),
    .mm_power  (mm_power),
    .mm_result (mm_result),
    .mm_done   (mm_done),
    .op_done   (op_done),
    .op_result (op_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      acc    <= '0;
      base   <= '0;
      e      <= '0;
      msg_q  <= '0;
      mod_q  <= '0;
      err_q  <= 1'b0;
      issued <= 1'b0;
      go     <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      result <= '0;
    end else begin
      go    <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            msg_q  <= msg;
            e      <= exponent;
            mod_q  <= modulus;
            acc    <= ONE;
            busy   <= 1'b1;
            issued <= 1'b0;
            if (modulus == '0) begin
              err_q <= 1'b1;
              state <= ST_FINISH;
            end else begin
              err_q <= 1'b0;
              state <= ST_REDUCE;
            end
          end
        end
        ST_REDUCE: begin
          // msg*1 mod n brings the base into range before the first multiply
          if (!issued) begin
            go     <= 1'b1;
            op_a   <= msg_q;
            op_b   <= ONE;
            issued <= 1'b1;
          end else if (op_done) begin
            base   <= op_result;
            issued <= 1'b0;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (e == '0)
            state <= ST_FINISH;
          else if (e[0])
            state <= ST_MUL;
          else
            state <= ST_SQR;
        end
        ST_MUL: begin
          if (!issued) begin
            go     <= 1'b1;
            op_a   <= acc;
            op_b   <= base;
            issued <= 1'b1;
          end else if (op_done) begin
            acc    <= op_result;
            issued <= 1'b0;
            state  <= ST_SQR;
          end
        end
        ST_SQR: begin
`ifdef MODEXP_SKIP_LAST_SQR_EN
          if (e == ONE) begin
            e     <= '0;
            state <= ST_CHECK;
          end else
`endif
          if (!issued) begin
            go     <= 1'b1;
            op_a   <= base;
            op_b   <= base;
            issued <= 1'b1;
          end else if (op_done) begin
            base   <= op_result;
            e      <= e >> 1;
            issued <= 1'b0;
            state  <= ST_CHECK;
          end
        end
        ST_FINISH: begin
          // acc is already reduced, except the initial 1 when the modulus is 1
          result <= (err_q || (mod_q == ONE)) ? '0 : acc;
          done   <= 1'b1;
          error  <= err_q;
          err_q  <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_controller.sv
// Directed bench for modexp_controller with a behavioural modmult responder.
module tb_modexp_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] msg, exponent, modulus;
  logic        busy, done, error;
  logic [31:0] result;
  logic        mm_ready;
  logic [31:0] mm_base, mm_power, mm_denominator;
  logic [31:0] mm_result;
  logic        mm_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  modexp_controller #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .msg            (msg),
    .exponent       (exponent),
    .modulus        (modulus),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .result         (result),
    .mm_ready       (mm_ready),
    .mm_base        (mm_base),
    .mm_power       (mm_power),
    .mm_denominator (mm_denominator),
    .mm_result      (mm_result),
    .mm_done        (mm_done)
  );

  // Behavioural modmult: accepts on mm_ready, answers after 1..3 cycles,
  // holds mm_done until mm_ready falls.
  int          op_cnt = 0;
  int          stab_err = 0;
  int          mcnt;
  logic [1:0]  mst;
  logic [63:0] prod;
  logic        rdy_q;
  logic [31:0] base_q, pow_q, den_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mst       <= 2'd0;
      mm_done   <= 1'b0;
      mm_result <= 32'd0;
      rdy_q     <= 1'b0;
      mcnt      <= 0;
    end else begin
      rdy_q  <= mm_ready;
      base_q <= mm_base;
      pow_q  <= mm_power;
      den_q  <= mm_denominator;
      if (mm_ready && rdy_q &&
          (mm_base !== base_q || mm_power !== pow_q || mm_denominator !== den_q))
        stab_err <= stab_err + 1;
      case (mst)
        2'd0: if (mm_ready) begin
          op_cnt <= op_cnt + 1;
          prod   <= (mm_denominator == 32'd0) ? 64'd0 :
                    ({32'd0, mm_base} * {32'd0, mm_power}) % {32'd0, mm_denominator};
          mcnt   <= 1 + (op_cnt % 3);
          mst    <= 2'd1;
        end
        2'd1: if (mcnt <= 1) begin
          mm_done   <= 1'b1;
          mm_result <= prod[31:0];
          mst       <= 2'd2;
        end else begin
          mcnt <= mcnt - 1;
        end
        default: if (!mm_ready) begin
          mm_done <= 1'b0;
          mst     <= 2'd0;
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Runs one request; optionally re-pulses start with other operands while busy.
  task automatic run_vec(input logic [31:0] m, input logic [31:0] x, input logic [31:0] n,
                         input int restart_at,
                         output logic [31:0] res, output logic [31:0] res_hold,
                         output logic er, output int dones, output int errs,
                         output int ops, output logic busy1, output logic timed_out);
    int o0;
    int after;
    bit seen;
    @(negedge clk);
    msg = m; exponent = x; modulus = n; start = 1'b1;
    o0 = op_cnt;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    dones = 0; errs = 0; er = 1'b0; res = 32'hDEAD_BEEF;
    seen = 1'b0; after = 0; timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c == restart_at) begin
        msg = 32'd7; exponent = 32'd9; modulus = 32'd11; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (error) errs++;
      if (done) begin
        dones++;
        if (!seen) begin
          res = result;
          er  = error;
        end
        seen = 1'b1;
      end
      if (seen) after++;
      if (after > 6) begin
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    res_hold = result;
    ops = op_cnt - o0;
  endtask

  typedef struct {
    logic [31:0] m;
    logic [31:0] x;
    logic [31:0] n;
    logic [31:0] res;
    logic        err;
    int          ops;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [31:0] res, res_hold;
    logic er, busy1, to;
    int dones, errs, ops, exp_ops, skip;
`ifdef MODEXP_SKIP_LAST_SQR_EN
    skip = 1;
`else
    skip = 0;
`endif

    vecs[0] = '{32'd4,          32'd13, 32'd497,        32'd445, 1'b0, 8};
    vecs[1] = '{32'd5,          32'd3,  32'd13,         32'd8,   1'b0, 5};
    vecs[2] = '{32'd524,        32'd1,  32'd31,         32'd28,  1'b0, 3};
    vecs[3] = '{32'd7,          32'd0,  32'd31,         32'd1,   1'b0, 1};
    vecs[4] = '{32'd7,          32'd0,  32'd1,          32'd0,   1'b0, 1};
    vecs[5] = '{32'd9,          32'd5,  32'd0,          32'd0,   1'b1, 0};
    vecs[6] = '{32'd2,          32'd10, 32'd1000,       32'd24,  1'b0, 7};
    vecs[7] = '{32'd3,          32'd5,  32'd1,          32'd0,   1'b0, 6};
    vecs[8] = '{32'hFFFF_FFFF,  32'd2,  32'hFFFF_FFFB,  32'd16,  1'b0, 4};

    reset_n = 1'b0; start = 1'b0; msg = '0; exponent = '0; modulus = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_result", result, 0);
    check("rst_mm_ready", mm_ready, 0);
    check("rst_mm_operands", {mm_base | mm_power | mm_denominator}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i].m, vecs[i].x, vecs[i].n, -1, res, res_hold, er, dones, errs, ops, busy1, to);
      exp_ops = vecs[i].ops - ((skip != 0 && vecs[i].x != 0) ? 1 : 0);
      check($sformatf("v%0d_timeout", i), to, 0);
      check($sformatf("v%0d_busy", i), busy1, 1);
      check($sformatf("v%0d_result", i), res, vecs[i].res);
      check($sformatf("v%0d_result_held", i), res_hold, vecs[i].res);
      check($sformatf("v%0d_error", i), er, vecs[i].err);
      check($sformatf("v%0d_error_pulses", i), errs, vecs[i].err ? 1 : 0);
      check($sformatf("v%0d_done_pulses", i), dones, 1);
      check($sformatf("v%0d_ops", i), ops, exp_ops);
    end

    // start re-pulsed with different operands while busy must be ignored
    run_vec(32'd4, 32'd13, 32'd497, 10, res, res_hold, er, dones, errs, ops, busy1, to);
    check("restart_timeout", to, 0);
    check("restart_result", res, 445);
    check("restart_done_pulses", dones, 1);
    check("restart_ops", ops, 8 - skip);

    // reset asserted while an op is outstanding
    @(negedge clk);
    msg = 32'd4; exponent = 32'd13; modulus = 32'd497; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (mm_ready) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("midrst_ready_seen", to, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_mm_ready", mm_ready, 0);
    check("midrst_mm_operands", {mm_base | mm_power | mm_denominator}, 0);
    check("midrst_done_error", {done, error}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(32'd5, 32'd3, 32'd13, -1, res, res_hold, er, dones, errs, ops, busy1, to);
    check("postrst_timeout", to, 0);
    check("postrst_result", res, 8);
    check("postrst_done_pulses", dones, 1);

    check("operand_stability", stab_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
